// File: rtl/buffer_register_seq_if.sv
// rtl/buffer_register_seq_if.sv - sense, TR-load and status bundle of the buffer register sequencer
// master drives requests and sense data; slave is the buffer register.
interface buffer_register_seq_if #(
  parameter int WIDTH = 13,
  parameter int NMOD  = 4,
  parameter int SELW  = (NMOD > 1) ? $clog2(NMOD) : 1
);
  logic                    READ_REQ;
  logic [SELW-1:0]         MOD_SEL;
  logic [NMOD*WIDTH-1:0]   SA;
  logic [NMOD-1:0]         SAP;
  logic                    CBR;
  logic                    SBRY;
  logic                    SBRZ;
  logic [WIDTH-1:0]        TR;
  logic [WIDTH-1:0]        BR;
  logic                    BRP;
  logic                    BUSY;
  logic                    REGEN;
  logic                    DONE;
  logic                    PERR;

  modport master (
    output READ_REQ, MOD_SEL, SA, SAP, CBR, SBRY, SBRZ, TR,
    input  BR, BRP, BUSY, REGEN, DONE, PERR
  );

  modport slave (
    input  READ_REQ, MOD_SEL, SA, SAP, CBR, SBRY, SBRZ, TR,
    output BR, BRP, BUSY, REGEN, DONE, PERR
  );
endinterface

// File: rtl/buffer_register_seq.sv
// rtl/buffer_register_seq.sv - syllable buffer register with clear/sense/check/regenerate read sequencer
// Idle cycles accept direct clear and half-word TR loads; reads OR-accumulate one module's sense amps.
module buffer_register_seq #(
  parameter int               WIDTH     = 13,
  parameter int               NMOD      = 4,
  parameter int               SENSE_CYC = 2,
  parameter logic [WIDTH-1:0] Z_MASK    = 13'h024B
) (
  input logic                  V1,
  input logic                  RST,
  buffer_register_seq_if.slave bus
);
  localparam int SELW = (NMOD > 1) ? $clog2(NMOD) : 1;
  localparam int CW   = (SENSE_CYC > 1) ? $clog2(SENSE_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_SENSE, S_CHECK, S_RGN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] br_q;
  logic             brp_q;
  logic             perr_q;
  logic             busy_q;
  logic             regen_q;
  logic             done_q;
  logic [SELW-1:0]  sel_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] ld_d;
  logic [WIDTH-1:0] br_idle_d;
  logic [WIDTH-1:0] sense_d;
  logic             sense_p_d;

  always_comb begin
    ld_d      = (bus.SBRY ? ~Z_MASK : '0) | (bus.SBRZ ? Z_MASK : '0);
    br_idle_d = (bus.CBR ? '0 : br_q) | (bus.TR & ld_d);
  end

  // Selects that name no fitted module contribute nothing to the accumulation.
  always_comb begin
    sense_d   = '0;
    sense_p_d = 1'b0;
    for (int m = 0; m < NMOD; m++) begin
      if (sel_q == SELW'(m)) begin
        sense_d   = bus.SA[m*WIDTH +: WIDTH];
        sense_p_d = bus.SAP[m];
      end
    end
  end

  always_ff @(posedge V1) begin
    if (RST) begin
      state_q <= S_IDLE;
      br_q    <= '0;
      brp_q   <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
      regen_q <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.READ_REQ) begin
            sel_q   <= bus.MOD_SEL;
            busy_q  <= 1'b1;
            state_q <= S_CLR;
          end else begin
            br_q <= br_idle_d;
            if (bus.CBR || (ld_d != '0)) brp_q <= ~^br_idle_d;
          end
        end
        S_CLR: begin
          br_q    <= '0;
          brp_q   <= 1'b0;
          perr_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_SENSE;
        end
        S_SENSE: begin
          br_q  <= br_q | sense_d;
          brp_q <= brp_q | sense_p_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(SENSE_CYC - 1)) state_q <= S_CHECK;
        end
        S_CHECK: begin
          // Odd parity over {BR,BRP} is good; an even count flags the read.
          perr_q  <= ~^{br_q, brp_q};
          regen_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= S_RGN;
        end
        S_RGN: begin
          regen_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.BR    = br_q;
  assign bus.BRP   = brp_q;
  assign bus.PERR  = perr_q;
  assign bus.BUSY  = busy_q;
  assign bus.REGEN = regen_q;
  assign bus.DONE  = done_q;
endmodule

// File: tb/tb_buffer_register_seq.sv
// tb/tb_buffer_register_seq.sv - bench for buffer_register_seq
// Timeline model of the read sequence and idle loads, checked every cycle, plus directed literals.
module tb_buffer_register_seq;
  localparam int             W  = 13;
  localparam int             N  = 4;
  localparam int             SC = 2;
  localparam logic [W-1:0]   ZM = 13'h024B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buffer_register_seq_if #(.WIDTH(W), .NMOD(N)) bus ();
  buffer_register_seq_if #(.WIDTH(W), .NMOD(3)) bus3 ();

  buffer_register_seq #(.WIDTH(W), .NMOD(N), .SENSE_CYC(SC), .Z_MASK(ZM)) dut (
    .V1(clk), .RST(rst), .bus(bus.slave)
  );
  buffer_register_seq #(.WIDTH(W), .NMOD(3), .SENSE_CYC(SC), .Z_MASK(ZM)) dut3 (
    .V1(clk), .RST(rst), .bus(bus3.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: age is the cycle number within a read (1 = clear cycle), -1 when idle.
  logic [W-1:0] m_br = '0;
  logic         m_brp = 1'b0;
  logic         m_perr = 1'b0;
  int           age = -1;
  int           msel = 0;
  bit           armed = 1'b0;
  logic [W-1:0] m_ld, m_nb;

  always @(posedge clk) begin
    if (rst) begin
      m_br = '0; m_brp = 1'b0; m_perr = 1'b0; age = -1; armed = 1'b1;
    end else if (age < 0) begin
      if (bus.READ_REQ) begin
        age  = 1;
        msel = int'(bus.MOD_SEL);
      end else begin
        m_ld = (bus.SBRY ? ~ZM : '0) | (bus.SBRZ ? ZM : '0);
        m_nb = (bus.CBR ? '0 : m_br) | (bus.TR & m_ld);
        if (bus.CBR || m_ld != '0) m_brp = ~^m_nb;
        m_br = m_nb;
      end
    end else begin
      if (age == 1) begin
        m_br = '0; m_brp = 1'b0; m_perr = 1'b0;
      end else if (age <= 1 + SC) begin
        m_br  = m_br | bus.SA[msel*W +: W];
        m_brp = m_brp | bus.SAP[msel];
      end else if (age == 2 + SC) begin
        m_perr = ~^{m_br, m_brp};
      end
      age = (age == 3 + SC) ? -1 : age + 1;
    end
  end

  always @(negedge clk) begin
    if (armed)
      chk("cycle {BR,BRP,BUSY,REGEN,DONE,PERR}",
          {bus.BR, bus.BRP, bus.BUSY, bus.REGEN, bus.DONE, bus.PERR},
          {m_br, m_brp, age >= 1, age == 3 + SC, age == 3 + SC, m_perr});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.READ_REQ = 1'b0; bus.MOD_SEL = '0; bus.SA = '0; bus.SAP = '0;
    bus.CBR = 1'b0; bus.SBRY = 1'b0; bus.SBRZ = 1'b0; bus.TR = '0;
    bus3.READ_REQ = 1'b0; bus3.MOD_SEL = '0; bus3.SA = '0; bus3.SAP = '0;
    bus3.CBR = 1'b0; bus3.SBRY = 1'b0; bus3.SBRZ = 1'b0; bus3.TR = '0;
  endtask

  task automatic run_read(input string nm, input int sel, input logic [W-1:0] sa1,
                          input logic [W-1:0] sa2, input logic sap,
                          input logic [W-1:0] exp_br, input logic exp_brp, input logic exp_perr);
    int n;
    int got;
    bus.SA = '1;
    bus.SAP = '1;
    bus.SA[sel*W +: W] = sa1;
    bus.SAP[sel] = sap;
    bus.MOD_SEL = 2'(sel);
    bus.READ_REQ = 1'b1;
    step();
    bus.READ_REQ = 1'b0;
    n = 0;
    got = -1;
    while (n < 20) begin
      step();
      n++;
      if (n == 1) chk({nm, "_perr_cleared"}, bus.PERR, 0);
      if (n == 2) bus.SA[sel*W +: W] = sa2;
      if (bus.DONE) begin
        got = n + 1;
        break;
      end
    end
    chk({nm, "_done_cycle"}, got, 3 + SC);
    chk({nm, "_br"}, bus.BR, exp_br);
    chk({nm, "_brp"}, bus.BRP, exp_brp);
    chk({nm, "_perr"}, bus.PERR, exp_perr);
    chk({nm, "_model_br"}, m_br, exp_br);
    chk({nm, "_model_perr"}, m_perr, exp_perr);
    idle_inputs();
    step();
  endtask

  initial begin
    int n;
    int first;
    int second;
    int dones;
    bit saw_done;

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("reset_outputs", {bus.BR, bus.BRP, bus.BUSY, bus.REGEN, bus.DONE, bus.PERR}, 0);
    rst = 1'b0;
    step();

    run_read("read_mod2", 2, 13'h1ABC, 13'h0001, 1'b0, 13'h1ABD, 1'b0, 1'b0);
    run_read("parity_fault", 0, 13'h0003, 13'h0003, 1'b0, 13'h0003, 1'b0, 1'b1);
    run_read("read_after_fault", 2, 13'h1ABC, 13'h0001, 1'b0, 13'h1ABD, 1'b0, 1'b0);
    run_read("read_mod3", 3, 13'h0F00, 13'h00F0, 1'b1, 13'h0FF0, 1'b1, 1'b0);

    bus.CBR = 1'b1; bus.SBRY = 1'b1; bus.SBRZ = 1'b1; bus.TR = 13'h1FFF;
    step();
    chk("load_full_br", bus.BR, 13'h1FFF);
    chk("load_full_brp", bus.BRP, 1'b0);
    bus.SBRY = 1'b0;
    step();
    chk("cbr_sbrz_br", bus.BR, 13'h024B);
    chk("cbr_sbrz_brp", bus.BRP, 1'b0);
    bus.CBR = 1'b0; bus.SBRZ = 1'b0; bus.SBRY = 1'b1; bus.TR = 13'h0004;
    step();
    chk("sbry_br", bus.BR, 13'h024F);
    chk("sbry_brp", bus.BRP, 1'b1);
    chk("sbry_model_br", m_br, 13'h024F);
    idle_inputs();
    step();
    chk("idle_hold_br", bus.BR, 13'h024F);

    bus.SA = '0; bus.SAP = '0;
    bus.SA[1*W +: W] = 13'h0100;
    bus.MOD_SEL = 2'd1;
    bus.READ_REQ = 1'b1; bus.CBR = 1'b1; bus.SBRY = 1'b1; bus.TR = 13'h1FFF;
    step();
    first = -1; second = -1; n = 0;
    while (n < 30 && second < 0) begin
      step();
      n++;
      if (bus.DONE) begin
        chk("busy_mask_br", bus.BR, 13'h0100);
        chk("busy_mask_perr", bus.PERR, 1'b0);
        if (first < 0) first = n + 1;
        else second = n + 1;
      end
    end
    idle_inputs();
    chk("busy_mask_first_done", first, 3 + SC);
    chk("busy_mask_second_done", second, (3 + SC) + (4 + SC));
    step(); step();

    bus.SA = '1; bus.SAP = '1; bus.MOD_SEL = 2'd0; bus.READ_REQ = 1'b1;
    step();
    bus.READ_REQ = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_mid_sense", {bus.BR, bus.BRP, bus.BUSY, bus.REGEN, bus.DONE, bus.PERR}, 0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      step();
      if (bus.DONE || bus.REGEN) saw_done = 1'b1;
    end
    chk("rst_no_regen", saw_done, 1'b0);
    idle_inputs();

    bus3.SA = '1; bus3.SAP = '1; bus3.MOD_SEL = 2'd3; bus3.READ_REQ = 1'b1;
    step();
    bus3.READ_REQ = 1'b0;
    first = -1; n = 0;
    while (n < 20 && first < 0) begin
      step();
      n++;
      if (bus3.DONE) first = n + 1;
    end
    chk("nmod3_done_cycle", first, 3 + SC);
    chk("nmod3_br", bus3.BR, 0);
    chk("nmod3_brp", bus3.BRP, 1'b0);
    chk("nmod3_perr", bus3.PERR, 1'b1);
    idle_inputs();

    dones = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] a, b;
      step();
      if (bus.DONE) dones++;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      rst          = ($urandom_range(0, 199) == 0);
      bus.READ_REQ = ($urandom_range(0, 3) == 0);
      bus.MOD_SEL  = 2'($urandom);
      bus.SA       = 52'(a & b & {$urandom, $urandom});
      bus.SAP      = 4'($urandom);
      bus.CBR      = ($urandom_range(0, 3) == 0);
      bus.SBRY     = ($urandom_range(0, 2) == 0);
      bus.SBRZ     = ($urandom_range(0, 2) == 0);
      bus.TR       = 13'($urandom);
    end
    rst = 1'b0;
    idle_inputs();
    repeat (10) step();
    chk("random_reads_completed", dones > 20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
